io_bus_sequencer: RTL and testbench

IO_BUS_SEQUENCER -- requirements
Module: io_bus_sequencer

---
 rtl/io_bus_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/io_bus_sequencer.sv | 115 +++++++++++
 tb/tb_io_bus_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus sequencer: bus-cycle states,
// default bus widths and the device address window.
package io_bus_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 16;

  // Address window decoded by the attached IO device.
  localparam logic [15:0] IO_WINDOW_BASE  = 16'h0000;
  localparam logic [15:0] IO_WINDOW_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    T4
  } state_t;

  function automatic logic in_io_window(input logic [15:0] addr);
    return (addr >= IO_WINDOW_BASE) && (addr <= IO_WINDOW_LIMIT);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the grant is combinational and the
// priority pointer moves away from the winner whenever advance is pulsed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester that wins the next tie.
  logic prio;

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11)
      grant = prio ? 2'b10 : 2'b01;
    else
      grant = req;
  end

  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (advance && (grant != 2'b00))
      prio <= grant[0];
  end

endmodule

// File: rtl/io_bus_sequencer.sv
// Arbitrates two requesters onto a T1-T4 strobed IO bus cycle with
// io_ready wait states, timeout abort and registered completion pulses.
module io_bus_sequencer
  import io_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req,
  input  logic [1:0]                    req_wr,
  input  logic [1:0][ADDRESS_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [1:0]                    done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDRESS_WIDTH-1:0]      io_addr,
  output logic [DATA_WIDTH-1:0]         io_wdata,
  input  logic [DATA_WIDTH-1:0]         io_rdata,
  output logic                          rd_n,
  output logic                          wr_n,
  input  logic                          io_ready
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  logic [1:0]        grant;
  logic              advance;
  logic              sel;
  logic              cur_wr;
  logic [WAIT_W-1:0] wait_cnt;

  assign advance = (state == IDLE) && (grant != 2'b00);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      cur_wr   <= 1'b0;
      wait_cnt <= '0;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      done     <= 2'b00;
      err      <= 1'b0;
      rdata    <= '0;
      io_addr  <= '0;
      io_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 2'b00;
          err  <= 1'b0;
          if (advance) begin
            state    <= T1;
            sel      <= grant[1];
            cur_wr   <= req_wr[grant[1]];
            io_addr  <= req_addr[grant[1]];
            io_wdata <= req_wdata[grant[1]];
          end
        end
        T1: begin
          state <= T2;
          rd_n  <= 1'b0;
          // The device decodes a write as both strobes low together.
          wr_n  <= ~cur_wr;
        end
        T2: begin
          state    <= T3;
          wait_cnt <= '0;
        end
        T3: begin
          if (io_ready) begin
            state <= T4;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            done  <= sel ? 2'b10 : 2'b01;
            err   <= 1'b0;
            if (!cur_wr)
              rdata <= io_rdata;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            // This wait cycle is the last one allowed: abort with err.
            if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
              state <= T4;
              rd_n  <= 1'b1;
              wr_n  <= 1'b1;
              done  <= sel ? 2'b10 : 2'b01;
              err   <= 1'b1;
            end
          end
        end
        T4: begin
          state    <= IDLE;
          done     <= 2'b00;
          err      <= 1'b0;
          io_addr  <= '0;
          io_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Randomized self-checking bench for io_bus_sequencer against a
// transaction-level model of arbitration, latency, timeout and read capture.
module tb_io_bus_sequencer;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           req = 2'b00;
  logic [1:0]           req_wr = 2'b00;
  logic [1:0][AW-1:0]   req_addr = '0;
  logic [1:0][DW-1:0]   req_wdata = '0;
  logic [1:0]           done;
  logic                 err;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        io_addr;
  logic [DW-1:0]        io_wdata;
  logic [DW-1:0]        io_rdata = '0;
  logic                 rd_n;
  logic                 wr_n;
  logic                 io_ready = 1'b1;

  int            n_checks = 0;
  int            n_fail = 0;
  int            n_txn = 0;
  int            last_win = 1;
  logic [DW-1:0] exp_rdata = '0;
  bit            in_t4 = 1'b0;

  always #5 clk = ~clk;

  io_bus_sequencer #(
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .io_ready  (io_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    req_wr       = 2'($urandom);
    req_addr[0]  = AW'($urandom);
    req_addr[1]  = AW'($urandom);
    req_wdata[0] = DW'($urandom);
    req_wdata[1] = DW'($urandom);
    io_rdata     = DW'($urandom);
  endtask

  // One bus transaction: pat is the req pattern, w the number of io_ready-low
  // T3 cycles the device inserts, abort asserts rst during the first T3 cycle.
  task automatic do_txn(input logic [1:0] pat, input int w, input bit abort);
    int            win;
    int            dcyc;
    bit            tmo;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [DW-1:0] dev;
    win  = (pat == 2'b11) ? ((last_win == 0) ? 1 : 0) : (pat[1] ? 1 : 0);
    ew   = req_wr[win];
    ea   = req_addr[win];
    ed   = req_wdata[win];
    dev  = io_rdata;
    tmo  = (w >= TO);
    dcyc = 3 + (tmo ? TO : w + 1);
    req  = pat;
    io_ready = 1'b1;
    if (in_t4) begin
      step();
      check("idle_addr", 32'(io_addr), 32'h0);
      check("idle_done", 32'(done), 32'h0);
      check("idle_strobes", 32'({rd_n, wr_n}), 32'h3);
    end
    for (int j = 1; j <= dcyc; j++) begin
      step();
      io_ready = !tmo && (j >= 3 + w);
      if (j < dcyc) check("done_early", 32'(done), 32'h0);
      if (j == 1) begin
        check("t1_addr", 32'(io_addr), 32'(ea));
        check("t1_wdata", 32'(io_wdata), 32'(ed));
        check("t1_strobes", 32'({rd_n, wr_n}), 32'h3);
        // Inputs changing mid-transaction must not leak into the bus cycle.
        req_wr       = 2'($urandom);
        req_addr[0]  = AW'($urandom);
        req_addr[1]  = AW'($urandom);
        req_wdata[0] = DW'($urandom);
        req_wdata[1] = DW'($urandom);
      end else if (j < dcyc) begin
        check("strobe_rd", 32'(rd_n), 32'h0);
        check("strobe_wr", 32'(wr_n), 32'(!ew));
        check("hold_addr", 32'(io_addr), 32'(ea));
      end
      if (abort && j == 3) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_strobes", 32'({rd_n, wr_n}), 32'h3);
        check("rst_addr", 32'(io_addr), 32'h0);
        check("rst_wdata", 32'(io_wdata), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        last_win  = 1;
        exp_rdata = '0;
        in_t4     = 1'b0;
        io_ready  = 1'b1;
        n_txn++;
        $display("txn %0d req=%b win=%0d wr=%0b addr=%h waits=%0d aborted by reset", n_txn, pat, win, ew, ea, w);
        return;
      end
      if (j == dcyc) begin
        check("done_vec", 32'(done), (win == 1) ? 32'h2 : 32'h1);
        check("done_err", 32'(err), 32'(tmo));
        if (!ew && !tmo) exp_rdata = dev;
        check("rdata", 32'(rdata), 32'(exp_rdata));
        check("t4_strobes", 32'({rd_n, wr_n}), 32'h3);
        check("t4_addr", 32'(io_addr), 32'(ea));
        check("t4_wdata", 32'(io_wdata), 32'(ed));
      end
    end
    last_win = win;
    in_t4    = 1'b1;
    io_ready = 1'b1;
    n_txn++;
    $display("txn %0d req=%b win=%0d wr=%0b addr=%h waits=%0d timeout=%0b rdata=%h", n_txn, pat, win, ew, ea, w, tmo, rdata);
  endtask

  initial begin
    int w;
    step();
    step();
    rst = 1'b0;
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_addr", 32'(io_addr), 32'h0);
    check("reset_wdata", 32'(io_wdata), 32'h0);
    check("reset_strobes", 32'({rd_n, wr_n}), 32'h3);

    // Zero-wait read from requester 0.
    rand_inputs();
    req_wr[0] = 1'b0; req_addr[0] = 16'hFF05; io_rdata = 8'hA5;
    do_txn(2'b01, 0, 1'b0);
    // Zero-wait write from requester 1.
    rand_inputs();
    req_wr[1] = 1'b1; req_addr[1] = 16'h1C10; req_wdata[1] = 8'h3C;
    do_txn(2'b10, 0, 1'b0);
    // Both requesting: alternation 0,1,0,1 back to back.
    for (int k = 0; k < 4; k++) begin
      rand_inputs();
      do_txn(2'b11, 0, 1'b0);
    end
    // Three wait states on a read.
    rand_inputs();
    req_wr[0] = 1'b0;
    do_txn(2'b01, 3, 1'b0);
    // Device never ready: timeout keeps the previous rdata.
    rand_inputs();
    req_wr[1] = 1'b0;
    do_txn(2'b10, 40, 1'b0);
    // Reset in T3 of a write, then a normal transaction.
    rand_inputs();
    req_wr[0] = 1'b1;
    do_txn(2'b01, 2, 1'b1);
    rand_inputs();
    do_txn(2'b11, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      rand_inputs();
      w = ($urandom_range(0, 6) == 0) ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 2));
      do_txn(2'($urandom_range(1, 3)), w, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
